// File: rtl/mem_responder_pkg.sv
// Shared types and constants for the wait-state memory responder.
package mem_responder_pkg;

   localparam int unsigned DEF_DEPTH       = 64;
   localparam int unsigned DEF_WAIT_CYCLES = 2;
   localparam int unsigned CNT_W           = 4;
   localparam int unsigned DATA_W          = 32;

   typedef enum logic [1:0] {
      IDLE,
      WAIT,
      RESP
   } state_t;

   typedef struct packed {
      logic              we;
      logic [31:0]       addr;
      logic [DATA_W-1:0] wdata;
   } req_t;

endpackage

// File: rtl/resp_ram.sv
// Word storage for mem_responder: synchronous write, combinational read, no reset.
module resp_ram import mem_responder_pkg::*; #(
   parameter int unsigned DEPTH = DEF_DEPTH,
   parameter int unsigned IDX_W = 6
) (
   input  logic              clk,
   input  logic              we,
   input  logic [IDX_W-1:0]  addr,
   input  logic [DATA_W-1:0] wdata,
   output logic [DATA_W-1:0] rdata
);

   logic [DATA_W-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) begin
         mem[addr] <= wdata;
      end
   end

   assign rdata = mem[addr];

endmodule

// File: rtl/mem_responder.sv
// Valid/ready memory target with programmable wait states.
// Optional address checking enabled by defining MEM_RESPONDER_ERRCHK_EN.
module mem_responder import mem_responder_pkg::*; #(
   parameter int unsigned DEPTH       = DEF_DEPTH,
   parameter int unsigned WAIT_CYCLES = DEF_WAIT_CYCLES
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [31:0] rsp_rdata,
   output logic        rsp_err
);

   localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   state_t             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               accept;
   logic               enter_resp;
   req_t               in_req, cap_q, cur_req;
   logic [29:0]        word;
   logic [IDX_W-1:0]   idx;
   logic               addr_err;
   logic               ram_we;
   logic [DATA_W-1:0]  ram_rdata;
   logic [DATA_W-1:0]  rsp_data_d;

   assign in_req = '{we: req_we, addr: req_addr, wdata: req_wdata};

   // With zero wait states the response is built straight from the bus inputs.
   assign cur_req = (state_q == IDLE) ? in_req : cap_q;
   assign word    = cur_req.addr[31:2];
   assign idx     = IDX_W'(word % 30'(DEPTH));

`ifdef MEM_RESPONDER_ERRCHK_EN
   assign addr_err = (cur_req.addr[1:0] != 2'b00) || (word >= 30'(DEPTH));
`else
   logic unused_lsbs;
   assign unused_lsbs = ^cur_req.addr[1:0];
   assign addr_err    = 1'b0;
`endif

   assign ram_we     = enter_resp && cur_req.we && !addr_err;
   assign rsp_data_d = addr_err ? '0 : (cur_req.we ? cur_req.wdata : ram_rdata);

   resp_ram #(
      .DEPTH (DEPTH),
      .IDX_W (IDX_W)
   ) u_ram (
      .clk   (clk),
      .we    (ram_we),
      .addr  (idx),
      .wdata (cur_req.wdata),
      .rdata (ram_rdata)
   );

   // Next-state and wait counter.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      accept  = 1'b0;
      case (state_q)
         IDLE: begin
            if (req_valid && req_ready) begin
               accept = 1'b1;
               if (WAIT_CYCLES == 0) begin
                  state_d = RESP;
               end else begin
                  state_d = WAIT;
                  cnt_d   = CNT_W'(WAIT_CYCLES - 1);
               end
            end
         end
         WAIT: begin
            if (cnt_q == '0) begin
               state_d = RESP;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         RESP: begin
            if (rsp_valid && rsp_ready) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign enter_resp = (state_d == RESP) && (state_q != RESP);

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         req_ready <= 1'b1;
         rsp_valid <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         req_ready <= (state_d == IDLE);
         rsp_valid <= (state_d == RESP);
      end
   end

   // Request capture and response payload.
   always_ff @(posedge clk) begin
      if (!reset) begin
         cap_q     <= '0;
         rsp_rdata <= '0;
         rsp_err   <= 1'b0;
      end else begin
         if (accept) begin
            cap_q <= in_req;
         end
         if (enter_resp) begin
            rsp_rdata <= rsp_data_d;
            rsp_err   <= addr_err;
         end
      end
   end

endmodule

// File: doc/mem_responder.md
# mem_responder

Word-addressed memory responder that serves the processor's data/instruction bus as the target side of a valid/ready request–response protocol. It replaces the ideal zero-latency `mem` with a programmable wait-state memory: it accepts one request, holds it for a fixed number of wait cycles, commits writes, then returns read data or a write acknowledgement under response backpressure. It sits between the bus initiator (core or bus adapter) and the backing storage array.

## Interface
- DEPTH, 64: number of 32-bit words; index width is clog2(DEPTH).
- WAIT_CYCLES, 2: wait states between request accept and response (0..15).
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-low reset (asserted when 0).
- req_valid  input  1  initiator presents a request.
- req_ready  output  1  responder can accept a request this cycle.
- req_we  input  1  1 = write, 0 = read.
- req_addr  input  32  byte address; word index = req_addr[31:2].
- req_wdata  input  32  write data.
- rsp_valid  output  1  response is present.
- rsp_ready  input  1  initiator accepts the response.
- rsp_rdata  output  32  read data, or echoed write data for writes.
- rsp_err  output  1  response carries an error (see Configuration).

## Operation
- FSM states: IDLE, WAIT, RESP.
- IDLE: req_ready=1. On req_valid&req_ready capture we/addr/wdata; go to WAIT with counter=WAIT_CYCLES-1, or straight to RESP if WAIT_CYCLES=0.
- WAIT: req_ready=0; counter decrements each cycle; on counter==0 go to RESP.
- Transition into RESP: write commits to array (single write per request); for reads rsp_rdata loads array[index]; for writes rsp_rdata loads captured wdata.
- RESP: rsp_valid=1; rsp_rdata/rsp_err held stable until rsp_ready=1; on rsp_valid&rsp_ready return to IDLE.
- No overlap: req_ready=0 in WAIT and RESP; a new request is accepted no earlier than the cycle after the handshake completes.
- Read-after-write to same index returns the new value.
- Reset (reset==0 at a clock edge): state IDLE, req_ready=1 after release, rsp_valid=0, rsp_rdata=0, rsp_err=0, counter=0. Array contents are not reset.
- Reset during WAIT discards the pending request; a write not yet committed never reaches the array. Reset during RESP drops the response.

## Timing
- All outputs registered; no combinational path from inputs to outputs.
- Accept at edge T → rsp_valid=1 from edge T+WAIT_CYCLES+1.
- With rsp_ready held high: one transaction every WAIT_CYCLES+2 cycles.
- Write visible to a subsequent read immediately after entering RESP.

## Configuration
- MEM_RESPONDER_ERRCHK_EN defined: a request with req_addr[1:0]!=0 or req_addr[31:2]>=DEPTH completes with normal timing but rsp_err=1, rsp_rdata=0, and no write to the array.
- Not defined: req_addr[1:0] ignored, index = req_addr[31:2] modulo DEPTH (wrap-around), rsp_err tied to 0.

## Structure
- Package mem_responder_pkg: state enum type (IDLE, WAIT, RESP), default DEPTH and WAIT_CYCLES constants, counter width constant (4 bits).
- One sub-module: resp_ram (DEPTH×32, synchronous write, combinational read), instantiated once; FSM, counter, capture and response registers in the top.

## Test plan
- Reset then idle: hold reset=0 for 3 cycles, release → req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0.
- Write then read, WAIT_CYCLES=2: write 0xDEADBEEF to 0x10 → rsp_valid 3 cycles after accept with rsp_rdata=0xDEADBEEF; read 0x10 → rsp_rdata=0xDEADBEEF, rsp_err=0.
- Backpressure: read with rsp_ready=0 for 5 cycles → rsp_valid and rsp_rdata stable, req_ready=0 throughout; rsp_ready=1 → IDLE next cycle.
- WAIT_CYCLES=0: read accepted at T → rsp_valid at T+1; back-to-back with rsp_ready=1 → one accept every 2 cycles.
- Reset mid-WAIT: write 0x12345678 to 0x8, assert reset in WAIT → read 0x8 returns prior value, not 0x12345678.
- Address checks: with MEM_RESPONDER_ERRCHK_EN, write 0x55 to 0x102 (misaligned) or to 0x100 (index 64, DEPTH=64) → rsp_err=1, rsp_rdata=0, array unchanged; without it, write to 0x100 lands at index 0 and rsp_err=0.
